// File: rtl/seven_seg_frame_decoder_pkg.sv
// Shared segment-pattern constants for the 7-segment receive path and display checkers.
// Patterns are seg[7:1] = a..g with the decimal point excluded.
package seven_seg_frame_decoder_pkg;
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1110011;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] NIB_E     = 4'hE;
  localparam logic [3:0] NIB_BLANK = 4'hF;

  localparam int SEG_DP_BIT = 0;
endpackage

// File: rtl/seven_seg_frame_decoder_seg_pattern_decode.sv
// Combinational inverse of the digit-to-segment encoding.
// Unknown glyphs decode to the blank nibble with err raised.
module seg_pattern_decode
  import seven_seg_frame_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       err
);

  always_comb begin
    nibble = NIB_BLANK;
    err    = 1'b0;
    case (seg)
      SEG_0:     nibble = 4'd0;
      SEG_1:     nibble = 4'd1;
      SEG_2:     nibble = 4'd2;
      SEG_3:     nibble = 4'd3;
      SEG_4:     nibble = 4'd4;
      SEG_5:     nibble = 4'd5;
      SEG_6:     nibble = 4'd6;
      SEG_7:     nibble = 4'd7;
      SEG_8:     nibble = 4'd8;
      SEG_9:     nibble = 4'd9;
      SEG_E:     nibble = NIB_E;
      SEG_BLANK: nibble = NIB_BLANK;
      default:   err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_frame_decoder.sv
// Rebuilds displayed digits from a scanned 7-segment bus: stability filter,
// per-digit capture slots, frame assembly and valid/ready output handshake.
module seven_seg_frame_decoder
  import seven_seg_frame_decoder_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [NUM_DIGITS-1:0]   err_out,
  output logic                    overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [NUM_DIGITS+7:0]   sample;
  logic [CW-1:0]           cnt, cnt_next;
  logic [NUM_DIGITS-1:0]   seen, seen_next;
  logic [4*NUM_DIGITS-1:0] slot_nib, slot_nib_next;
  logic [NUM_DIGITS-1:0]   slot_dp, slot_dp_next;
  logic [NUM_DIGITS-1:0]   slot_err, slot_err_next;
  logic                    changed, capture, frame_done;
  logic [3:0]              dec_nib;
  logic                    dec_err;

  seg_pattern_decode u_decode (
    .seg    (seg_in[7:1]),
    .nibble (dec_nib),
    .err    (dec_err)
  );

  always_comb begin
    changed = ({an_in, seg_in} != sample);
    if (changed)              cnt_next = CW'(1);
    else if (cnt == CNT_MAX)  cnt_next = cnt;
    else                      cnt_next = cnt + CW'(1);

    // Fire only on the edge the count arrives at the threshold, so one capture per dwell.
    capture = $onehot(an_in) && (cnt_next == CNT_MAX) && (changed || cnt != CNT_MAX);

    slot_nib_next = slot_nib;
    slot_dp_next  = slot_dp;
    slot_err_next = slot_err;
    seen_next     = seen;
    if (capture) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (an_in[i]) begin
          slot_nib_next[4*i +: 4] = dec_nib;
          slot_dp_next[i]         = seg_in[SEG_DP_BIT];
          slot_err_next[i]        = dec_err;
        end
      end
      seen_next = seen | an_in;
    end
    frame_done = &seen_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample     <= '0;
      cnt        <= '0;
      seen       <= '0;
      slot_nib   <= '1;
      slot_dp    <= '0;
      slot_err   <= '0;
      out_valid  <= 1'b0;
      digits_out <= '1;
      dp_out     <= '0;
      err_out    <= '0;
      overrun    <= 1'b0;
    end else begin
      sample   <= {an_in, seg_in};
      cnt      <= cnt_next;
      slot_nib <= slot_nib_next;
      slot_dp  <= slot_dp_next;
      slot_err <= slot_err_next;
      if (frame_done) begin
        seen <= '0;
        if (!out_valid || out_ready) begin
          digits_out <= slot_nib_next;
          dp_out     <= slot_dp_next;
          err_out    <= slot_err_next;
          out_valid  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else begin
        seen <= seen_next;
        if (out_valid && out_ready) out_valid <= 1'b0;
      end
    end
  end

endmodule
